// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// pipeline writeback and a buffered auxiliary result source (divider, uncached
// loads). The pipeline always wins; auxiliary results wait in a small FIFO and
// a registered stall request is raised once the FIFO head has starved too long.
// Optional build macro WB_PORT_ARBITER_PERF_EN adds perf_conflicts/perf_kills.
module wb_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_wreg,
  input  logic [ADDR_W-1:0]        pipe_waddr,
  input  logic [DATA_W-1:0]        pipe_wdata,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [ADDR_W-1:0]        aux_waddr,
  input  logic [DATA_W-1:0]        aux_wdata,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   aux_pending
`ifdef WB_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]              perf_conflicts,
  output logic [31:0]              perf_kills
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);

  function automatic logic [WW-1:0] sat_inc(input logic [WW-1:0] v);
    return (v >= MAX_W) ? v : v + WW'(1);
  endfunction

  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0]  live_q, live_d;
  logic [ADDR_W-1:0] addr_q [0:DEPTH-1];
  logic [ADDR_W-1:0] addr_d [0:DEPTH-1];
  logic [DATA_W-1:0] data_q [0:DEPTH-1];
  logic [DATA_W-1:0] data_d [0:DEPTH-1];
  logic [WW-1:0]     wait_q, wait_d;
  logic              stall_q, stall_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              pipe_grant, fifo_empty, push, pop;
`ifdef WB_PORT_ARBITER_PERF_EN
  logic [31:0]       conf_q, conf_d, kills_q, kills_d, kill_cnt;
`endif

  // Handshake and grant decisions; dead heads drain even under a pipeline write
  always_comb begin
    pipe_grant = pipe_wreg && (pipe_waddr != '0);
    fifo_empty = (count_q == '0);
    aux_ready  = !rst && (count_q != CW'(DEPTH));
    push       = aux_valid && aux_ready;
    pop        = !fifo_empty && (!pipe_grant || !live_q[rd_ptr_q]);
  end

  // FIFO bookkeeping, kill of stale entries, port mux and starvation counter
  always_comb begin
    live_d     = live_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wait_d     = wait_q;
`ifdef WB_PORT_ARBITER_PERF_EN
    kill_cnt   = '0;
`endif
    // A younger pipeline write to the same register supersedes buffered results
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_grant && live_q[i] && (addr_q[i] == pipe_waddr)) begin
        live_d[i] = 1'b0;
`ifdef WB_PORT_ARBITER_PERF_EN
        kill_cnt  = kill_cnt + 32'd1;
`endif
      end
    end
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PW'(1);
    end
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q] = aux_waddr;
      data_d[wr_ptr_q] = aux_wdata;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (pipe_grant) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end else if (pop && live_q[rd_ptr_q] && (addr_q[rd_ptr_q] != '0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = addr_q[rd_ptr_q];
      rf_wdata_d = data_q[rd_ptr_q];
    end
    if (fifo_empty || pop) begin
      wait_d = '0;
    end else if (live_q[rd_ptr_q]) begin
      wait_d = sat_inc(wait_q);
    end
    stall_d = (wait_d >= MAX_W);
`ifdef WB_PORT_ARBITER_PERF_EN
    conf_d  = conf_q + 32'((!fifo_empty && live_q[rd_ptr_q] && pipe_grant) ? 1 : 0);
    kills_d = kills_q + kill_cnt;
`endif
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      live_q     <= '0;
      wait_q     <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
`ifdef WB_PORT_ARBITER_PERF_EN
      conf_q     <= '0;
      kills_q    <= '0;
`endif
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      live_q     <= live_d;
      wait_q     <= wait_d;
      stall_q    <= stall_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
`ifdef WB_PORT_ARBITER_PERF_EN
      conf_q     <= conf_d;
      kills_q    <= kills_d;
`endif
    end
  end

  // FIFO payload storage; validity is tracked by live_q, so no reset needed
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign stall_req   = stall_q;
  assign aux_pending = count_q;
`ifdef WB_PORT_ARBITER_PERF_EN
  assign perf_conflicts = conf_q;
  assign perf_kills     = kills_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file writes are queued
// as stimulus is issued and a negedge monitor checks every rf_we pulse.
module tb_wb_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_wreg;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          aux_valid;
  logic          aux_ready;
  logic [AW-1:0] aux_waddr;
  logic [DW-1:0] aux_wdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          stall_req;
  logic [1:0]    aux_pending;
`ifdef WB_PORT_ARBITER_PERF_EN
  logic [31:0]   perf_conflicts;
  logic [31:0]   perf_kills;
`endif

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] sb [$];

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wreg(pipe_wreg), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .aux_pending(aux_pending)
`ifdef WB_PORT_ARBITER_PERF_EN
    , .perf_conflicts(perf_conflicts), .perf_kills(perf_kills)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sb.push_back({a, d});
  endtask

  // Monitor: every register-file write must match the oldest queued expectation
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rf_write_unexpected actual=%0h:%0h required=no write", rf_waddr, rf_wdata);
      end else begin
        logic [AW+DW-1:0] e;
        e = sb.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          errors++;
          $display("FAIL rf_write actual=%0h:%0h required=%0h:%0h",
                   rf_waddr, rf_wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pipe_wreg = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    aux_valid = 1'b0; aux_waddr = '0; aux_wdata = '0;
    cyc(); cyc();
    chk("reset_aux_ready", aux_ready, 0);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_waddr", rf_waddr, 0);
    chk("reset_rf_wdata", rf_wdata, 0);
    chk("reset_stall", stall_req, 0);
    chk("reset_pending", aux_pending, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", aux_ready, 1);

    // Pipeline only: one-cycle latency, then idle holds address/data
    pipe_wreg = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'h1234;
    expect_wr(5'd5, 32'h1234);
    cyc();
    chk("pipe_rf_we", rf_we, 1);
    chk("pipe_aux_ready", aux_ready, 1);
    pipe_wreg = 1'b0;
    cyc();
    chk("idle_rf_we", rf_we, 0);
    chk("idle_hold_addr", rf_waddr, 5);
    chk("idle_hold_data", rf_wdata, 32'h1234);

    // Write to $0 is not a write
    pipe_wreg = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h55;
    cyc();
    chk("zero_rf_we", rf_we, 0);
    chk("zero_hold_data", rf_wdata, 32'h1234);
    pipe_wreg = 1'b0;

    // Aux only: buffered one cycle, then written; granted alongside a $0 write
    aux_valid = 1'b1; aux_waddr = 5'd8; aux_wdata = 32'hDEADBEEF;
    expect_wr(5'd8, 32'hDEADBEEF);
    cyc();
    aux_valid = 1'b0;
    chk("aux_pending_1", aux_pending, 1);
    pipe_wreg = 1'b1; pipe_waddr = 5'd0;
    cyc();
    pipe_wreg = 1'b0;
    chk("aux_rf_we", rf_we, 1);
    chk("aux_pending_0", aux_pending, 0);

    // Starvation: head waddr=3 blocked by pipeline writes to 9
    aux_valid = 1'b1; aux_waddr = 5'd3; aux_wdata = 32'h33;
    cyc();
    aux_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      pipe_wreg = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'(32'h900 + i);
      expect_wr(5'd9, 32'(32'h900 + i));
      cyc();
      chk($sformatf("starve_stall_%0d", i), stall_req, (i >= 4) ? 1 : 0);
    end
    pipe_wreg = 1'b0;
    expect_wr(5'd3, 32'h33);
    cyc();
    chk("starve_grant_we", rf_we, 1);
    chk("starve_stall_clear", stall_req, 0);

    // Kill: pipeline write to 7 supersedes the buffered aux result for 7
    aux_valid = 1'b1; aux_waddr = 5'd7; aux_wdata = 32'hAA;
    cyc();
    aux_valid = 1'b0;
    pipe_wreg = 1'b1; pipe_waddr = 5'd7; pipe_wdata = 32'hBB;
    expect_wr(5'd7, 32'hBB);
    cyc();
    pipe_wreg = 1'b0;
    chk("kill_pending_before_drain", aux_pending, 1);
    cyc();
    chk("kill_drain_we", rf_we, 0);
    chk("kill_pending_after_drain", aux_pending, 0);
`ifdef WB_PORT_ARBITER_PERF_EN
    chk("perf_kills", perf_kills, 1);
    chk("perf_conflicts", perf_conflicts, 6);
`endif

    // Full: two pushes under pipeline writes, third push refused even while popping
    pipe_wreg = 1'b1; pipe_waddr = 5'd10; pipe_wdata = 32'hA0;
    aux_valid = 1'b1; aux_waddr = 5'd11; aux_wdata = 32'hB1;
    expect_wr(5'd10, 32'hA0);
    cyc();
    pipe_wdata = 32'hA1;
    aux_waddr = 5'd12; aux_wdata = 32'hB2;
    expect_wr(5'd10, 32'hA1);
    cyc();
    chk("full_ready", aux_ready, 0);
    chk("full_pending", aux_pending, 2);
    pipe_wreg = 1'b0;
    aux_waddr = 5'd13; aux_wdata = 32'hB3;
    expect_wr(5'd11, 32'hB1);
    cyc();
    aux_valid = 1'b0;
    chk("full_pop_pending", aux_pending, 1);
    chk("full_ready_after_pop", aux_ready, 1);
    expect_wr(5'd12, 32'hB2);
    cyc();
    chk("full_drained", aux_pending, 0);
    cyc(); cyc();

    // Reset mid-operation with two buffered entries and stall asserted
    aux_valid = 1'b1; aux_waddr = 5'd14; aux_wdata = 32'hC1;
    pipe_wreg = 1'b1; pipe_waddr = 5'd9;
    for (int i = 0; i < 5; i++) begin
      pipe_wdata = 32'(32'hD00 + i);
      expect_wr(5'd9, 32'(32'hD00 + i));
      if (i == 1) begin aux_waddr = 5'd15; aux_wdata = 32'hC2; end
      if (i == 2) aux_valid = 1'b0;
      cyc();
    end
    chk("pre_reset_stall", stall_req, 1);
    chk("pre_reset_pending", aux_pending, 2);
    pipe_wreg = 1'b0;
    rst = 1'b1;
    #1;
    chk("in_reset_ready", aux_ready, 0);
    cyc();
    chk("post_reset_we", rf_we, 0);
    chk("post_reset_stall", stall_req, 0);
    chk("post_reset_pending", aux_pending, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("post_reset_ready", aux_ready, 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
